// File: rtl/exe_mem_buf_if.sv
// Execute-to-memory writeback interface.
// The buffer uses the slave modport. The execute/memory side (or a bench) uses the master modport.
// The forwarding outputs exist only when EXE_MEM_BUF_FWD_EN is defined.
interface exe_mem_buf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic              reg_we_i;
  logic [DATA_W-1:0] reg_wdata_i;
  logic              valid_o;
  logic              ready_i;
  logic [ADDR_W-1:0] reg_waddr_o;
  logic              reg_we_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`ifdef EXE_MEM_BUF_FWD_EN
  logic              fwd_we_o;
  logic [ADDR_W-1:0] fwd_waddr_o;
  logic [DATA_W-1:0] fwd_wdata_o;
`endif

  modport slave (
    input  flush_i, valid_i, reg_waddr_i, reg_we_i, reg_wdata_i, ready_i,
    output ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, stall_cnt_o
`ifdef EXE_MEM_BUF_FWD_EN
    , output fwd_we_o, fwd_waddr_o, fwd_wdata_o
`endif
  );

  modport master (
    output flush_i, valid_i, reg_waddr_i, reg_we_i, reg_wdata_i, ready_i,
    input  ready_o, valid_o, reg_waddr_o, reg_we_o, reg_wdata_o, stall_cnt_o
`ifdef EXE_MEM_BUF_FWD_EN
    , input fwd_we_o, fwd_waddr_o, fwd_wdata_o
`endif
  );
endinterface

// File: rtl/exe_mem_buf.sv
// Execute/memory pipeline buffer.
// A 2-entry skid buffer (main + skid) holds the writeback triple (waddr, we, wdata).
// It supports a synchronous flush and x0 write suppression.
// A saturating stall counter is kept for debug.
// Optional feature: define EXE_MEM_BUF_FWD_EN to add ID-stage forwarding outputs.
// Those outputs present the youngest valid entry.
module exe_mem_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  exe_mem_buf_if.slave  bus
);
  // The state encoding is the pair {main_v, skid_v}. The pair (0,1) is never reachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e            state_r, state_next_s;
  logic              ready_r;
  logic [ADDR_W-1:0] main_waddr_r, skid_waddr_r;
  logic              main_we_r, skid_we_r;
  logic [DATA_W-1:0] main_wdata_r, skid_wdata_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic accept_s, consume_s;
  logic load_main_in_s, load_main_skid_s, load_skid_s, clr_we_s;

  // Writes to x0 are turned into bubbles at capture time.
  function automatic logic cap_we(input logic we, input logic [ADDR_W-1:0] waddr);
    return we & (waddr != {ADDR_W{1'b0}});
  endfunction

  assign accept_s  = bus.valid_i & ready_r;
  assign consume_s = state_r[1] & bus.ready_i;

  // State register; ready is registered as "skid free in the next state".
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      ready_r <= ~state_next_s[0];
    end
  end

  // Next-state logic; flush overrides any accept/consume in the same cycle.
  always_comb begin
    state_next_s = state_r;
    if (bus.flush_i) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (consume_s && !accept_s) begin
            state_next_s = ST_EMPTY;
          end else if (accept_s && !consume_s) begin
            state_next_s = ST_FULL;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL:  state_next_s = consume_s ? ST_ONE : ST_FULL;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Datapath load controls derived from the current state and handshake.
  always_comb begin
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    clr_we_s         = 1'b0;
    if (bus.flush_i) begin
      clr_we_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: load_main_in_s = accept_s;
        ST_ONE: begin
          load_main_in_s = accept_s & consume_s;
          load_skid_s    = accept_s & ~consume_s;
        end
        ST_FULL:  load_main_skid_s = consume_s;
        default:  clr_we_s = 1'b1;
      endcase
    end
  end

  // Main and skid entry registers. Data stays stale after a consume or flush; only we is cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_waddr_r <= {ADDR_W{1'b0}};
      main_we_r    <= 1'b0;
      main_wdata_r <= {DATA_W{1'b0}};
      skid_waddr_r <= {ADDR_W{1'b0}};
      skid_we_r    <= 1'b0;
      skid_wdata_r <= {DATA_W{1'b0}};
    end else begin
      if (clr_we_s) begin
        main_we_r <= 1'b0;
        skid_we_r <= 1'b0;
      end else if (load_main_in_s) begin
        main_waddr_r <= bus.reg_waddr_i;
        main_we_r    <= cap_we(bus.reg_we_i, bus.reg_waddr_i);
        main_wdata_r <= bus.reg_wdata_i;
      end else if (load_main_skid_s) begin
        main_waddr_r <= skid_waddr_r;
        main_we_r    <= skid_we_r;
        main_wdata_r <= skid_wdata_r;
      end
      if (load_skid_s) begin
        skid_waddr_r <= bus.reg_waddr_i;
        skid_we_r    <= cap_we(bus.reg_we_i, bus.reg_waddr_i);
        skid_wdata_r <= bus.reg_wdata_i;
      end
    end
  end

  // Saturating count of cycles in which mem stalls a valid result; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r[1] && !bus.ready_i && !bus.flush_i &&
                 (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.valid_o     = state_r[1];
  assign bus.ready_o     = ready_r;
  assign bus.reg_waddr_o = main_waddr_r;
  assign bus.reg_we_o    = main_we_r;
  assign bus.reg_wdata_o = main_wdata_r;
  assign bus.stall_cnt_o = stall_cnt_r;

`ifdef EXE_MEM_BUF_FWD_EN
  logic              fwd_we_s;
  logic [ADDR_W-1:0] fwd_waddr_s;
  logic [DATA_W-1:0] fwd_wdata_s;

  // Forward the youngest valid entry (skid before main); a flush kills the forward.
  always_comb begin
    fwd_we_s    = 1'b0;
    fwd_waddr_s = main_waddr_r;
    fwd_wdata_s = main_wdata_r;
    if (bus.flush_i) begin
      fwd_we_s = 1'b0;
    end else if (state_r[0]) begin
      fwd_we_s    = skid_we_r;
      fwd_waddr_s = skid_waddr_r;
      fwd_wdata_s = skid_wdata_r;
    end else if (state_r[1]) begin
      fwd_we_s = main_we_r;
    end else begin
      fwd_we_s = 1'b0;
    end
  end

  assign bus.fwd_we_o    = fwd_we_s;
  assign bus.fwd_waddr_o = fwd_waddr_s;
  assign bus.fwd_wdata_o = fwd_wdata_s;
`endif
endmodule

// File: tb/tb_exe_mem_buf.sv
// Self-checking bench for exe_mem_buf.
// It runs with a 4-bit stall counter so that saturation is reachable.
// A queue model holds the buffered entries. It is pushed on accept and popped on consume.
// Every output is compared each cycle.
module tb_exe_mem_buf;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic          we;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exe_mem_buf_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  exe_mem_buf #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  ent_t out_m;
  int   stall_m;
  logic cur_fl;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t y;
    check("valid_o", {31'd0, bus.valid_o}, {31'd0, q.size() > 0});
    check("ready_o", {31'd0, bus.ready_o}, {31'd0, q.size() < 2});
    check("waddr_o", {27'd0, bus.reg_waddr_o}, {27'd0, out_m.waddr});
    check("we_o", {31'd0, bus.reg_we_o}, {31'd0, out_m.we});
    check("wdata_o", bus.reg_wdata_o, out_m.data);
    check("stall_cnt", {28'd0, bus.stall_cnt_o}, stall_m);
`ifdef EXE_MEM_BUF_FWD_EN
    if (q.size() > 0) begin
      y = q[q.size()-1];
      check("fwd_we", {31'd0, bus.fwd_we_o}, {31'd0, y.we & ~cur_fl});
      if (!cur_fl) begin
        check("fwd_waddr", {27'd0, bus.fwd_waddr_o}, {27'd0, y.waddr});
        check("fwd_wdata", bus.fwd_wdata_o, y.data);
      end
    end else begin
      check("fwd_we_idle", {31'd0, bus.fwd_we_o}, 32'd0);
    end
`endif
  endtask

  task automatic model_reset();
    q.delete();
    out_m   = '0;
    stall_m = 0;
    cur_fl  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.valid_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.ready_i     = 1'b0;
    bus.reg_waddr_i = 5'd0;
    bus.reg_we_i    = 1'b0;
    bus.reg_wdata_i = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  // One clock of stimulus, followed by the model update and the comparison.
  task automatic cycle(input logic v, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] d, input logic rdy, input logic fl);
    logic acc, cons;
    ent_t e;
    @(negedge clk);
    bus.valid_i     = v;
    bus.reg_waddr_i = a;
    bus.reg_we_i    = we;
    bus.reg_wdata_i = d;
    bus.ready_i     = rdy;
    bus.flush_i     = fl;
    acc  = v & (q.size() < 2) & ~fl;
    cons = (q.size() > 0) & rdy;
    @(posedge clk);
    #1;
    if (!fl && q.size() > 0 && !rdy && stall_m != CNT_MAX) stall_m++;
    if (fl) begin
      q.delete();
      out_m.we = 1'b0;
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) begin
        e.waddr = a;
        e.we    = we & (a != 5'd0);
        e.data  = d;
        q.push_back(e);
      end
      if (q.size() > 0) out_m = q[0];
    end
    cur_fl = fl;
    check_outputs();
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
    bus.reg_waddr_i = 5'd0; bus.reg_we_i = 1'b0; bus.reg_wdata_i = 32'd0;
    model_reset();
    do_reset();

    // Streaming with the mem stage always ready.
    cycle(1'b1, 5'd3, 1'b1, 32'h11, 1'b1, 1'b0);
    cycle(1'b1, 5'd4, 1'b1, 32'h22, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // A write to x0 passes through as a bubble.
    cycle(1'b1, 5'd0, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: A, then B, then a third input that must be ignored.
    cycle(1'b1, 5'd1, 1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 5'd2, 1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 5'd7, 1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Stall counter: 5 stalled cycles, then hold until it saturates.
    do_reset();
    cycle(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("stall_5", {28'd0, bus.stall_cnt_o}, 32'd5);
    repeat (20) cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("stall_sat", {28'd0, bus.stall_cnt_o}, 32'd15);

    // Flush while FULL, with valid_i and ready_i both high in the same cycle.
    do_reset();
    cycle(1'b1, 5'd1, 1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 5'd2, 1'b1, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 1'b1, 32'h3, 1'b1, 1'b1);
    check("flush_valid", {31'd0, bus.valid_o}, 32'd0);
    check("flush_ready", {31'd0, bus.ready_o}, 32'd1);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);

    // FULL with main waddr=5 and skid waddr=6; the forward shows the skid entry.
    cycle(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0);
    cycle(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset asserted mid-cycle clears everything at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_we", {31'd0, bus.reg_we_o}, 32'd0);
    check("rst_waddr", {27'd0, bus.reg_waddr_o}, 32'd0);
    check("rst_wdata", bus.reg_wdata_o, 32'd0);
    check("rst_stall", {28'd0, bus.stall_cnt_o}, 32'd0);
`ifdef EXE_MEM_BUF_FWD_EN
    check("rst_fwd_we", {31'd0, bus.fwd_we_o}, 32'd0);
    check("rst_fwd_waddr", {27'd0, bus.fwd_waddr_o}, 32'd0);
    check("rst_fwd_wdata", bus.fwd_wdata_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            32'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/exe_mem_buf.md
Name: exe_mem_buf

Overview:
Pipeline buffer between the execute stage and the memory stage of the RV32 core. It captures the execute-stage writeback triple (waddr, we, wdata) under a valid/ready handshake and holds it in a 2-entry skid buffer (main + skid), so a memory-stage stall never drops a result. The buffer supports a synchronous flush, suppresses writes to x0, and keeps a saturating stall counter for debug.

Parameters:
DATA_W, 32, width of writeback data (matches RDATA_WIDTH)
ADDR_W, 5, register address width (matches RADDR_WIDTH)
CNT_W, 16, stall counter width

Ports:
clk_i  input  1  core clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush of all buffered entries
valid_i  input  1  execute stage presents a result this cycle
ready_o  output  1  buffer can accept this cycle (registered)
reg_waddr_i  input  ADDR_W  destination register from exe
reg_we_i  input  1  write enable from exe
reg_wdata_i  input  DATA_W  result from exe
valid_o  output  1  main entry holds a result for mem
ready_i  input  1  mem stage consumes main entry this cycle
reg_waddr_o  output  ADDR_W  main entry destination register
reg_we_o  output  1  main entry write enable
reg_wdata_o  output  DATA_W  main entry data
stall_cnt_o  output  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

Behaviour:
- Reset (rst_n_i=0, asynchronous): valid_o=0, reg_waddr_o=0, reg_we_o=0, reg_wdata_o=0, skid entry invalid and zeroed, ready_o=1, stall_cnt_o=0.
- Accept = valid_i & ready_o. Consume = valid_o & ready_i.
- Capture rule: a captured entry stores we = reg_we_i & (reg_waddr_i != 0). waddr and wdata are stored unchanged. An entry with we=0 is still a valid bubble and passes through.
- States, encoded by the (main_v, skid_v) pair: EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never occur.
- EMPTY: on accept, main loads the input; next state is ONE.
- ONE, consume and accept: main reloads from the input; state stays ONE.
- ONE, consume only: state becomes EMPTY; outputs keep their stale data but valid_o=0.
- ONE, accept only: the input goes to skid; state becomes FULL; ready_o=0 next cycle.
- FULL: ready_o=0, so there is no accept. On consume, main loads from skid, skid is invalidated, state becomes ONE, and ready_o=1 next cycle.
- ready_o is a register equal to !skid_v of the next state. It must not depend combinationally on ready_i.
- Latency: with ready_i held at 1, an input accepted in cycle N appears on the outputs in cycle N+1. Full throughput is 1 result per cycle.
- Ordering: results leave strictly in acceptance order. There is no duplication and no loss.
- Flush (synchronous): flush_i=1 overrides accept and consume in the same cycle. Next cycle both entries are invalid, reg_we_o=0, and ready_o=1. Data registers may hold stale values. stall_cnt_o is not cleared.
- Stall counter: increments by 1 in each cycle where valid_o=1 and ready_i=0 and flush_i=0. It holds at 2^CNT_W-1 and is only cleared by reset.
- Reset asserted mid-transfer: all entries are discarded immediately. There is no partial output.

Optional Feature:
Macro EXE_MEM_BUF_FWD_EN.
- When defined, the block adds three outputs for ID-stage operand forwarding: fwd_we_o (1), fwd_waddr_o (ADDR_W) and fwd_wdata_o (DATA_W). They combinationally present the youngest valid entry: skid if skid_v, else main if main_v. fwd_we_o is 0 when no entry is valid or during flush_i.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then stream with ready_i=1: issue waddr=3/we=1/data=0x11, then waddr=4/data=0x22 on consecutive cycles. Required: each appears one cycle later, valid_o=1 for 2 cycles, ready_o stays 1.
- x0 suppression: accept waddr=0, we=1, data=0xDEAD. Required: reg_we_o=0 and valid_o=1 next cycle.
- Backpressure: ready_i=0, accept A(0xA) then B(0xB). Required: ready_o=0 after B and valid_i ignored. Then ready_i=1: outputs show A, then B, in order, and ready_o returns to 1 the cycle after A leaves.
- Stall counter: hold ready_i=0 with valid_o=1 for 5 cycles. Required: stall_cnt_o=5. Force CNT_W=4 and hold 20 cycles: required stall_cnt_o=15 (saturated).
- Flush in FULL with valid_i=1 and ready_i=1 in the same cycle. Required: next cycle valid_o=0, reg_we_o=0, ready_o=1, and the input is dropped.
- With EXE_MEM_BUF_FWD_EN in FULL (main waddr=5, skid waddr=6/data=0x66). Required: fwd_waddr_o=6, fwd_wdata_o=0x66, fwd_we_o=1. After rst_n_i pulse low mid-cycle, all outputs are immediately 0.
